// File: rtl/serial_pattern_tx_if.sv
// serial_pattern_tx_if: request/pattern inputs and serial outputs of serial_pattern_tx
//   master drives start, pattern, nbits, reps and observes sout, sout_valid, busy, done
//   slave is the transmitter side
interface serial_pattern_tx_if #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4,
  parameter int LEN_W = $clog2(WIDTH) + 1
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] nbits;
  logic [REP_W-1:0] reps;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;
  modport master (output start, pattern, nbits, reps, input sout, sout_valid, busy, done);
  modport slave (input start, pattern, nbits, reps, output sout, sout_valid, busy, done);
endinterface

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: shifts a captured pattern out MSB first, repeated reps+1 times with GAP idle cycles between
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   tx_if  slave side of serial_pattern_tx_if (start/pattern/nbits/reps in; sout/sout_valid/busy/done out)
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4,
  parameter int GAP = 1
) (
  input logic clk,
  input logic rst_n,
  serial_pattern_tx_if.slave tx_if
);
  localparam int LEN_W = $clog2(WIDTH) + 1;
  localparam int IW = $clog2(WIDTH);
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_e;
  state_e state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [IW-1:0] last_q, last_d, idx_q, idx_d;
  logic [REP_W-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [LEN_W-1:0] len;
  logic sout_q, sout_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  always_comb begin
    len = (tx_if.nbits == '0 || tx_if.nbits > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : tx_if.nbits;
    state_d = state_q;
    pat_d = pat_q;
    last_d = last_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    gap_d = gap_q;
    case (state_q)
      S_IDLE: if (tx_if.start) begin
        state_d = S_SHIFT;
        pat_d = tx_if.pattern;
        last_d = IW'(len - LEN_W'(1));
        idx_d = IW'(len - LEN_W'(1));
        cnt_d = tx_if.reps;
      end
      S_SHIFT: if (idx_q != '0) idx_d = idx_q - IW'(1);
      else if (cnt_q != '0) begin
        cnt_d = cnt_q - REP_W'(1);
        if (GAP > 0) begin
          state_d = S_GAP;
          gap_d = GW'(GAP - 1);
        end else idx_d = last_q;
      end else state_d = S_DONE;
      S_GAP: if (gap_q == '0) begin
        state_d = S_SHIFT;
        idx_d = last_q;
      end else gap_d = gap_q - GW'(1);
      default: state_d = S_IDLE;
    endcase
    // outputs are registered from the next state so they line up with the state they describe
    sout_d = (state_d == S_SHIFT) & pat_d[idx_d];
    valid_d = state_d == S_SHIFT;
    busy_d = state_d == S_SHIFT || state_d == S_GAP;
    done_d = state_d == S_DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pat_q <= '0;
      last_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      gap_q <= '0;
      sout_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q <= pat_d;
      last_q <= last_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      gap_q <= gap_d;
      sout_q <= sout_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign tx_if.sout = sout_q;
  assign tx_if.sout_valid = valid_q;
  assign tx_if.busy = busy_q;
  assign tx_if.done = done_q;
endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial pattern transmitter: captures a parallel bit pattern on a start request and shifts it out one bit per clock, MSB first. It can repeat the pattern a programmed number of times, with fixed idle-low gap cycles between repetitions. It is the stimulus and driver side for the single-bit serial sequence/edge detectors in the FSM block set. It generates the `x`-style serial streams those detectors consume.

## Interface
- `WIDTH`, default 8: maximum pattern length in bits (≥2).
- `REP_W`, default 4: width of the repeat-count input.
- `GAP`, default 1: idle-low cycles inserted between repetitions (0 allowed = back-to-back).
- `LEN_W`, derived: `$clog2(WIDTH)+1`.

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `pattern`  in  WIDTH  bits to send; field is `pattern[nbits-1:0]`.
- `nbits`  in  LEN_W  bits per repetition.
- `reps`  in  REP_W  extra repetitions; total transmissions = `reps+1`.
- `sout`  out  1  serial data, registered.
- `sout_valid`  out  1  high while `sout` carries a pattern bit (SHIFT state only).
- `busy`  out  1  high from the first bit through the last bit.
- `done`  out  1  one-cycle pulse after the last bit.

## Operation
- States: IDLE, SHIFT, GAP, DONE. Registered Moore outputs; state and outputs are in one clocked domain.
- Reset (`rst_n`=0, any time, including mid-transfer) forces IDLE and `sout`=0, `sout_valid`=0, `busy`=0, `done`=0. No `done` is produced for an aborted transfer.
- **IDLE**: outputs low.
  - When `start`=1, capture `pattern`, effective length L, and `reps` into internal registers.
  - Go to SHIFT with bit index L-1 and repeat counter = `reps`.
- **Effective length L**:
  - `nbits`=0 → L=WIDTH.
  - `nbits`>WIDTH → L=WIDTH.
  - Otherwise L=`nbits`.
  - Bits of `pattern` at index ≥L are ignored.
- **SHIFT**: `sout` = captured bit at the current index, `sout_valid`=1, `busy`=1. Index decrements each cycle. After index 0:
  - If repeat counter >0 and GAP>0: decrement the counter, go to GAP.
  - If repeat counter >0 and GAP=0: decrement the counter, reload index L-1, stay in SHIFT.
  - If repeat counter =0: go to DONE.
- **GAP**: `sout`=0, `sout_valid`=0, `busy`=1 for exactly GAP cycles. Then reload index L-1 and go to SHIFT.
- **DONE**: `done`=1, `busy`=0, `sout`=0, for one cycle. Then go to IDLE.
- `start` is ignored in SHIFT, GAP and DONE; it is not queued.
- Input changes after capture do not affect the transfer in progress.

## Timing
- Latency: with `start` sampled at edge k, the first bit appears on `sout` after edge k+1 and is valid in cycle k+1.
- Busy window: `busy` stays high for (reps+1)·L + reps·GAP consecutive cycles. `done` fires in the cycle immediately after.
- Restart: earliest next accepted `start` is in the cycle after DONE (IDLE). Minimum spacing between two start samples = busy cycles + 2.
- L=1: one SHIFT cycle per repetition.
- Maximum transfer: L=WIDTH and `reps`=2^REP_W−1. The counter must not wrap.
- Asynchronous reset outputs clear immediately, without waiting for a clock edge. Release is synchronous to the next edge; the first accepted `start` is at the first edge after release.

## Test plan
1. **Single MSB-first transfer.** WIDTH=8, `pattern`=8'b1011_0010, `nbits`=8, `reps`=0, `start` at cycle 0.
   - `sout` = 1,0,1,1,0,0,1,0 in cycles 1–8.
   - `busy` high in cycles 1–8; `done` high in cycle 9 only.
2. **Short field.** `pattern`=8'hF6, `nbits`=4 → `sout` = 0,1,1,0 in cycles 1–4; `done` in cycle 5. Repeat with `nbits`=0 → all 8 bits of 8'hF6 sent.
3. **Repeats with gap.** `pattern`=4'b1101, `nbits`=4, `reps`=2, GAP=1.
   - Stream: 1101 0 1101 0 1101 over 14 busy cycles.
   - `sout_valid` low exactly in cycles 5 and 10.
   - Exactly 5 falling edges (1→0 transitions) observed on `sout` within the busy window.
4. **No gap.** GAP=0, `pattern`=2'b10, `nbits`=2, `reps`=3 → stream 10101010, `busy` for 8 cycles, `done` in cycle 9.
5. **Start while busy.** Hold `start`=1 continuously through scenario 1.
   - Second transfer's first bit appears in cycle 11: cycle 9 is DONE, cycle 10 is IDLE with `start` accepted.
   - No extra `done` pulses.
6. **Reset mid-transfer.** Drive `rst_n`=0 asynchronously mid-cycle during cycle 4 of scenario 1.
   - `sout`, `busy`, `sout_valid`, `done` go to 0 immediately, before the next clock edge.
   - No `done` pulse follows.
   - After release, a new `start` produces a clean full transfer.
